// File: rtl/c_join_ctrl.sv
// Clocked C-element join: waits for every synchronized producer request, raises one joined
// request, broadcasts the acknowledge back and completes return-to-zero. Optional watchdog: C_JOIN_TIMEOUT_EN.
module c_join_ctrl #(
    parameter int IN_NUM         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_NUM-1:0] in_req,
    output logic [IN_NUM-1:0] in_ack,
    output logic              out_req,
    input  logic              out_ack,
    input  logic              clr_err,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic              err_proto,
    output logic              err_timeout
);

    if (IN_NUM < 2 || SYNC_STAGES < 2 || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("c_join_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RTZ  = 2'd2
`ifdef C_JOIN_TIMEOUT_EN
        , S_ERR = 2'd3
`endif
    } state_t;

    // Stage 0 takes the raw input; the last stage is the only copy the FSM looks at.
    logic [SYNC_STAGES-1:0][IN_NUM-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0]             r_ack_sync;
    logic [IN_NUM-1:0]                  w_rq;
    logic                               w_ak;

    state_t            r_state, w_state_next;
    logic [IN_NUM-1:0] r_seen, w_seen_next;
    logic              r_out_req, w_out_req_next;
    logic              r_in_ack, w_in_ack_next;
    logic              r_busy, w_busy_next;
    logic [CNT_W-1:0]  r_txn_cnt, w_txn_cnt_next;
    logic              r_err_proto, w_err_proto_next;
    logic              w_proto_set;

`ifdef C_JOIN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd, w_wd_next;
    logic            w_wd_hit;
    logic            r_err_timeout, w_err_timeout_next;
    logic            w_to_set;
`endif

    assign w_rq = r_req_sync[SYNC_STAGES-1];
    assign w_ak = r_ack_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

`ifdef C_JOIN_TIMEOUT_EN
    assign w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_next   = r_state;
        w_seen_next    = r_seen;
        w_out_req_next = r_out_req;
        w_in_ack_next  = r_in_ack;
        w_txn_cnt_next = r_txn_cnt;
        w_proto_set    = 1'b0;
`ifdef C_JOIN_TIMEOUT_EN
        w_to_set       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // A producer that withdraws leaves seen in step with rq, so the error fires once.
                w_seen_next = w_rq;
                if ((|(r_seen & ~w_rq)) || w_ak) begin
                    w_proto_set = 1'b1;
                end
                if (&w_rq) begin
                    w_state_next   = S_REQ;
                    w_out_req_next = 1'b1;
                end
            end
            S_REQ: begin
                if (!(&w_rq)) begin
                    w_proto_set = 1'b1;
                end
                if (w_ak) begin
                    w_out_req_next = 1'b0;
                    w_in_ack_next  = 1'b1;
                    w_state_next   = S_RTZ;
                end
`ifdef C_JOIN_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_out_req_next = 1'b0;
                    w_to_set       = 1'b1;
                    w_state_next   = S_ERR;
                end
`endif
            end
            S_RTZ: begin
                if (!w_ak && (w_rq == '0)) begin
                    w_in_ack_next  = 1'b0;
                    w_seen_next    = '0;
                    w_txn_cnt_next = r_txn_cnt + CNT_W'(1);
                    w_state_next   = S_IDLE;
                end
`ifdef C_JOIN_TIMEOUT_EN
                else if (w_wd_hit) begin
                    w_in_ack_next = 1'b0;
                    w_to_set      = 1'b1;
                    w_state_next  = S_ERR;
                end
`endif
            end
`ifdef C_JOIN_TIMEOUT_EN
            S_ERR: begin
                if (clr_err && !w_ak && (w_rq == '0)) begin
                    w_seen_next  = '0;
                    w_state_next = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_next   = S_IDLE;
                w_out_req_next = 1'b0;
                w_in_ack_next  = 1'b0;
                w_seen_next    = '0;
            end
        endcase

        w_busy_next      = (w_state_next != S_IDLE);
        w_err_proto_next = w_proto_set | (r_err_proto & ~clr_err);
    end

`ifdef C_JOIN_TIMEOUT_EN
    // Any state change restarts the watchdog, which covers entry into REQ and RTZ.
    always_comb begin
        w_wd_next = r_wd;
        if (w_state_next != r_state) begin
            w_wd_next = '0;
        end else if ((r_state == S_REQ) || (r_state == S_RTZ)) begin
            w_wd_next = r_wd + WD_W'(1);
        end
        w_err_timeout_next = w_to_set | (r_err_timeout & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd          <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_wd          <= w_wd_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_seen      <= '0;
            r_out_req   <= 1'b0;
            r_in_ack    <= 1'b0;
            r_busy      <= 1'b0;
            r_txn_cnt   <= '0;
            r_err_proto <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_seen      <= w_seen_next;
            r_out_req   <= w_out_req_next;
            r_in_ack    <= w_in_ack_next;
            r_busy      <= w_busy_next;
            r_txn_cnt   <= w_txn_cnt_next;
            r_err_proto <= w_err_proto_next;
        end
    end

    assign in_ack    = {IN_NUM{r_in_ack}};
    assign out_req   = r_out_req;
    assign busy      = r_busy;
    assign txn_cnt   = r_txn_cnt;
    assign err_proto = r_err_proto;

endmodule

// File: tb/tb_c_join_ctrl.sv
// Scoreboard bench for c_join_ctrl: expected join counts are queued as each join is
// driven and compared when the controller finishes return-to-zero.
module tb_c_join_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_req;
    logic [2:0] in_ack;
    logic       out_req;
    logic       out_ack;
    logic       clr_err;
    logic       busy;
    logic [3:0] txn_cnt;
    logic       err_proto;
    logic       err_timeout;

    int n_cmp = 0;
    int n_mis = 0;
    int model_cnt = 0;
    int exp_q[$];

    c_join_ctrl #(
        .IN_NUM(3),
        .SYNC_STAGES(2),
        .CNT_W(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_req(in_req),
        .in_ack(in_ack),
        .out_req(out_req),
        .out_ack(out_ack),
        .clr_err(clr_err),
        .busy(busy),
        .txn_cnt(txn_cnt),
        .err_proto(err_proto),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait; the caller's following check reports an expired budget.
    task automatic wait_until(input int sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            case (sel)
                0: if (out_req) return;
                1: if (in_ack == 3'b111) return;
                2: if (in_ack == 3'b000 && !busy) return;
                default: if (err_timeout) return;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic push_join();
        model_cnt = (model_cnt + 1) % 16;
        exp_q.push_back(model_cnt);
    endtask

    task automatic finish_join(input string tag);
        int exp_c;
        wait_until(2, 20);
        exp_c = exp_q.pop_front();
        check({tag, ".txn_cnt"}, txn_cnt, exp_c);
        check({tag, ".in_ack_clr"}, in_ack, 0);
        $display("join %s: txn_cnt=%0d expected=%0d", tag, txn_cnt, exp_c);
        cycles(3);
        check({tag, ".cnt_stable"}, txn_cnt, exp_c);
    endtask

    // mode 0: req and ack drop together; mode 1: ack drops 10 cycles before req.
    task automatic do_join(input int mode, input string tag);
        in_req = 3'b111;
        push_join();
        wait_until(0, 20);
        check({tag, ".out_req"}, out_req, 1);
        out_ack = 1'b1;
        wait_until(1, 20);
        check({tag, ".in_ack_set"}, in_ack, 7);
        if (mode == 1) begin
            out_ack = 1'b0;
            cycles(10);
            check({tag, ".in_ack_hold"}, in_ack, 7);
            in_req = 3'b000;
            cycles(2);
            check({tag, ".in_ack_late"}, in_ack, 7);
        end else begin
            in_req  = 3'b000;
            out_ack = 1'b0;
        end
        finish_join(tag);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0;
        in_req = 3'b000;
        out_ack = 1'b0;
        clr_err = 1'b0;
        cycles(3);
        check("rst.in_ack", in_ack, 0);
        check("rst.out_req", out_req, 0);
        check("rst.busy", busy, 0);
        check("rst.txn_cnt", txn_cnt, 0);
        check("rst.err_proto", err_proto, 0);
        check("rst.err_timeout", err_timeout, 0);
        rst = 1'b1;
        cycles(2);

        // Basic join with staggered requests and exact latency checks.
        in_req = 3'b001;
        push_join();
        cycles(5);
        in_req = 3'b011;
        cycles(4);
        in_req = 3'b111;
        cycles(2);
        check("basic.out_req_early", out_req, 0);
        cycles(1);
        check("basic.out_req", out_req, 1);
        check("basic.busy", busy, 1);
        out_ack = 1'b1;
        cycles(2);
        check("basic.in_ack_early", in_ack, 0);
        cycles(1);
        check("basic.in_ack", in_ack, 7);
        check("basic.out_req_drop", out_req, 0);
        in_req = 3'b000;
        out_ack = 1'b0;
        cycles(3);
        check("basic.busy_done", busy, 0);
        finish_join("basic");
        check("basic.err_proto", err_proto, 0);

        do_join(1, "rtz_ack_first");
        do_join(0, "rtz_together");

        // Producer withdraws before the join completes.
        in_req = 3'b010;
        cycles(4);
        in_req = 3'b000;
        cycles(4);
        check("proto.err", err_proto, 1);
        check("proto.out_req", out_req, 0);
        check("proto.busy", busy, 0);
        pulse_clr();
        check("proto.clr", err_proto, 0);
        do_join(0, "proto_after");
        check("proto_after.err", err_proto, 0);

        // Consumer acknowledge while idle.
        out_ack = 1'b1;
        cycles(4);
        check("idle_ack.err", err_proto, 1);
        out_ack = 1'b0;
        cycles(3);
        pulse_clr();
        check("idle_ack.clr", err_proto, 0);

`ifdef C_JOIN_TIMEOUT_EN
        in_req = 3'b111;
        wait_until(0, 20);
        check("timeout.out_req", out_req, 1);
        cycles(15);
        check("timeout.not_yet", err_timeout, 0);
        cycles(1);
        check("timeout.err", err_timeout, 1);
        check("timeout.out_req_drop", out_req, 0);
        in_req = 3'b000;
        cycles(4);
        check("timeout.hold_err_state", busy, 1);
        pulse_clr();
        check("timeout.idle", busy, 0);
        check("timeout.cleared", err_timeout, 0);
        check("timeout.txn_cnt", txn_cnt, model_cnt);
`else
        in_req = 3'b111;
        wait_until(0, 20);
        check("nowd.out_req", out_req, 1);
        push_join();
        cycles(20);
        check("nowd.err_timeout", err_timeout, 0);
        check("nowd.out_req_hold", out_req, 1);
        out_ack = 1'b1;
        wait_until(1, 20);
        check("nowd.in_ack", in_ack, 7);
        in_req = 3'b000;
        out_ack = 1'b0;
        finish_join("nowd");
`endif

        // Asynchronous reset while in return-to-zero.
        in_req = 3'b111;
        wait_until(0, 20);
        out_ack = 1'b1;
        wait_until(1, 20);
        check("rstmid.in_rtz", in_ack, 7);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid.in_ack", in_ack, 0);
        check("rstmid.busy", busy, 0);
        check("rstmid.txn_cnt", txn_cnt, 0);
        in_req = 3'b000;
        out_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_cnt = 0;
        exp_q.delete();
        cycles(2);

        // Sixteen joins: count climbs to 15 then wraps to 0.
        for (int k = 0; k < 16; k++) begin
            do_join(k % 2, $sformatf("wrap%0d", k));
        end
        check("wrap.final", txn_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
